// File: rtl/icache_lookup_stage.sv
// First instruction-cache stage: flop-based tag/status arrays with a 1-cycle set lookup,
// write-first bypass on same-set collisions, and a status-array flush sequencer.
module icache_lookup_stage #(
    parameter int ADDR_WIDTH     = 16,
    parameter int OFFSET_WIDTH   = 4,
    parameter int NUM_SETS       = 16,
    parameter int NUM_WAYS       = 4,
    parameter int TAG_WIDTH      = 8,
    parameter int STATUS_WIDTH   = 2,
    parameter int METADATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic                             i_halt,
    input  logic                             i_flush,
    input  logic [ADDR_WIDTH-1:0]            i_r_addr,
    input  logic                             i_r_valid,
    input  logic [METADATA_WIDTH-1:0]        i_metadata,
    input  logic                             i_metadata_valid,
    input  logic [ADDR_WIDTH-1:0]            i_w_ta_addr,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]    i_w_ta_data,
    input  logic [NUM_WAYS-1:0]              i_w_ta_mask,
    input  logic                             i_w_ta_valid,
    input  logic [ADDR_WIDTH-1:0]            i_w_sa_addr,
    input  logic [NUM_WAYS*STATUS_WIDTH-1:0] i_w_sa_data,
    input  logic [NUM_WAYS-1:0]              i_w_sa_mask,
    input  logic                             i_w_sa_valid,
    output logic [NUM_WAYS*TAG_WIDTH-1:0]    o_ta_data,
    output logic                             o_ta_data_valid,
    output logic [NUM_WAYS*STATUS_WIDTH-1:0] o_sa_data,
    output logic                             o_sa_data_valid,
    output logic [METADATA_WIDTH-1:0]        o_metadata,
    output logic                             o_metadata_valid,
    output logic                             o_ready,
    output logic                             o_flush_busy
);
    localparam int SET_WIDTH = $clog2(NUM_SETS);
    localparam int TA_W      = NUM_WAYS * TAG_WIDTH;
    localparam int SA_W      = NUM_WAYS * STATUS_WIDTH;
    localparam logic [SET_WIDTH-1:0] LAST_SET = SET_WIDTH'(NUM_SETS - 1);

    typedef enum logic [0:0] {IDLE, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [SET_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic [TA_W-1:0] ta_mem [NUM_SETS];
    logic [SA_W-1:0] sa_mem [NUM_SETS];

    logic [SET_WIDTH-1:0] r_set, w_ta_set, w_sa_set;
    logic                 rd_acc, ta_we, sa_we;
    logic [TA_W-1:0]      ta_bm, ta_rd;
    logic [SA_W-1:0]      sa_bm, sa_rd;
    logic                 unused_addr_bits;

    // Handshake: every request input is consumed in a cycle where o_ready is high;
    // when o_ready is low nothing is consumed and the sender must hold its request.
    assign o_ready      = ~i_halt & (state_q == IDLE);
    assign o_flush_busy = (state_q == FLUSH);

    assign r_set    = i_r_addr[OFFSET_WIDTH +: SET_WIDTH];
    assign w_ta_set = i_w_ta_addr[OFFSET_WIDTH +: SET_WIDTH];
    assign w_sa_set = i_w_sa_addr[OFFSET_WIDTH +: SET_WIDTH];

    assign rd_acc = o_ready & i_r_valid;
    assign ta_we  = o_ready & i_w_ta_valid;
    assign sa_we  = o_ready & i_w_sa_valid;

    assign unused_addr_bits = ^{i_r_addr[ADDR_WIDTH-1:OFFSET_WIDTH+SET_WIDTH], i_r_addr[OFFSET_WIDTH-1:0],
                                i_w_ta_addr[ADDR_WIDTH-1:OFFSET_WIDTH+SET_WIDTH], i_w_ta_addr[OFFSET_WIDTH-1:0],
                                i_w_sa_addr[ADDR_WIDTH-1:OFFSET_WIDTH+SET_WIDTH], i_w_sa_addr[OFFSET_WIDTH-1:0]};

    always_comb begin
        ta_bm = '0;
        sa_bm = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            ta_bm[w*TAG_WIDTH +: TAG_WIDTH]       = {TAG_WIDTH{i_w_ta_mask[w]}};
            sa_bm[w*STATUS_WIDTH +: STATUS_WIDTH] = {STATUS_WIDTH{i_w_sa_mask[w]}};
        end
    end

    // Write-first: a same-set write in the read's cycle is visible on the read result.
    always_comb begin
        ta_rd = ta_mem[r_set];
        sa_rd = sa_mem[r_set];
        if (ta_we && (w_ta_set == r_set)) ta_rd = (ta_rd & ~ta_bm) | (i_w_ta_data & ta_bm);
        if (sa_we && (w_sa_set == r_set)) sa_rd = (sa_rd & ~sa_bm) | (i_w_sa_data & sa_bm);
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_flush && !i_halt) state_d = FLUSH;
            end
            FLUSH: begin
                if (!i_halt) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_q == LAST_SET) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                ta_mem[s] <= '0;
                sa_mem[s] <= '0;
            end
        end else if (!i_halt) begin
            if (ta_we) ta_mem[w_ta_set] <= (ta_mem[w_ta_set] & ~ta_bm) | (i_w_ta_data & ta_bm);
            // Writes are only accepted in IDLE, so they never race the flush clear.
            if (state_q == FLUSH) sa_mem[flush_cnt_q] <= '0;
            else if (sa_we)       sa_mem[w_sa_set] <= (sa_mem[w_sa_set] & ~sa_bm) | (i_w_sa_data & sa_bm);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            o_ta_data        <= '0;
            o_sa_data        <= '0;
            o_metadata       <= '0;
            o_ta_data_valid  <= 1'b0;
            o_sa_data_valid  <= 1'b0;
            o_metadata_valid <= 1'b0;
        end else if (!i_halt) begin
            o_ta_data_valid  <= rd_acc;
            o_sa_data_valid  <= rd_acc;
            o_metadata_valid <= rd_acc & i_metadata_valid;
            if (rd_acc) begin
                o_ta_data  <= ta_rd;
                o_sa_data  <= sa_rd;
                o_metadata <= i_metadata;
            end
        end
    end
endmodule
